// File: rtl/matrix_fmt_pkg.sv
// Shared types and constants for the matrix ASCII formatter.
// Holds the FSM state enums, the decimal power table and ASCII codes.
package matrix_fmt_pkg;

    localparam int unsigned MAX_DIM_DEF = 5;
    localparam int unsigned ADDR_W_DEF  = 9;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned DIM_W       = 3;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned POW_W       = 32;

    // Top-level sequencing: element fetch, conversion, separators, completion.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_CONV,
        ST_SEP,
        ST_FLUSH,
        ST_DONE
    } fmt_state_t;

    // Binary-to-decimal serializer states.
    typedef enum logic [1:0] {
        B_IDLE,
        B_SIGN,
        B_DIGIT,
        B_EMIT
    } b2d_state_t;

    localparam logic [POW_W-1:0] POW10 [0:9] = '{
        32'd1,
        32'd10,
        32'd100,
        32'd1000,
        32'd10000,
        32'd100000,
        32'd1000000,
        32'd10000000,
        32'd100000000,
        32'd1000000000
    };

    localparam logic [BYTE_W-1:0] ASC_SPACE = 8'h20;
    localparam logic [BYTE_W-1:0] ASC_MINUS = 8'h2D;
    localparam logic [BYTE_W-1:0] ASC_CR    = 8'h0D;
    localparam logic [BYTE_W-1:0] ASC_LF    = 8'h0A;
    localparam logic [BYTE_W-1:0] ASC_ZERO  = 8'h30;

endpackage

// File: rtl/bin2dec_serial.sv
// Serial signed 32-bit to ASCII decimal converter.
// Emits an optional '-' then the decimal digits with leading zeros
// suppressed, one byte per valid/ready handshake; last_c flags the final digit.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle pulse capturing value (only honoured when idle)
//   value             two's-complement input
//   ready             consumer accepts the presented byte this cycle
//   byte_c, valid_c   presented byte and its qualifier (combinational)
//   last_c            presented byte is the least significant digit
module bin2dec_serial
    import matrix_fmt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [POW_W-1:0]  value,
    input  logic              ready,
    output logic [BYTE_W-1:0] byte_c,
    output logic              valid_c,
    output logic              last_c
);

    b2d_state_t       state;
    b2d_state_t       state_next;
    logic             neg;
    logic [POW_W-1:0] mag;
    logic [3:0]       k;
    logic [3:0]       cnt;
    logic             seen;
    logic             emit_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= B_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and byte presentation.
    always_comb begin
        state_next = state;
        byte_c     = '0;
        valid_c    = 1'b0;
        last_c     = 1'b0;
        // A digit is printed once anything nonzero has appeared, or for the units place.
        emit_c     = (cnt != 4'd0) || seen || (k == 4'd0);
        case (state)
            B_IDLE: begin
                if (start) begin
                    state_next = B_SIGN;
                end
            end
            B_SIGN: begin
                if (neg) begin
                    valid_c = 1'b1;
                    byte_c  = ASC_MINUS;
                    if (ready) begin
                        state_next = B_DIGIT;
                    end
                end else begin
                    state_next = B_DIGIT;
                end
            end
            B_DIGIT: begin
                if (mag < POW10[k]) begin
                    state_next = B_EMIT;
                end
            end
            B_EMIT: begin
                if (emit_c) begin
                    valid_c = 1'b1;
                    byte_c  = ASC_ZERO + {4'd0, cnt};
                    last_c  = (k == 4'd0);
                    if (ready) begin
                        state_next = (k == 4'd0) ? B_IDLE : B_DIGIT;
                    end
                end else begin
                    state_next = B_DIGIT;
                end
            end
            default: state_next = B_IDLE;
        endcase
    end

    // Magnitude, digit position and repeated-subtraction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg  <= 1'b0;
            mag  <= '0;
            k    <= 4'd0;
            cnt  <= 4'd0;
            seen <= 1'b0;
        end else begin
            case (state)
                B_IDLE: begin
                    if (start) begin
                        neg  <= value[POW_W-1];
                        // Unsigned negation keeps -2^31 representable as 2^31.
                        mag  <= value[POW_W-1] ? ((~value) + 32'd1) : value;
                        k    <= 4'd9;
                        cnt  <= 4'd0;
                        seen <= 1'b0;
                    end
                end
                B_DIGIT: begin
                    if (mag >= POW10[k]) begin
                        mag <= mag - POW10[k];
                        cnt <= cnt + 4'd1;
                    end
                end
                B_EMIT: begin
                    if (!emit_c || ready) begin
                        seen <= seen | emit_c;
                        cnt  <= 4'd0;
                        if (k != 4'd0) begin
                            k <= k - 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/matrix_ascii_formatter.sv
// Reads an m x n matrix of signed 32-bit elements from synchronous storage
// and streams it as ASCII decimal text: space-separated, rows ended by CR LF.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   i_start, i_base_addr, i_m, i_n start request with base address and dims
//   o_rd_addr, i_rd_data           storage read port (data one cycle after address)
//   o_tx_data, o_tx_valid, i_tx_ready  byte stream to the UART transmitter
//   o_busy, o_done, o_err          status: active, completion pulse, rejected-start pulse
module matrix_ascii_formatter
    import matrix_fmt_pkg::*;
#(
    parameter int unsigned MAX_DIM = MAX_DIM_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [2:0]        i_m,
    input  logic [2:0]        i_n,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    fmt_state_t        state;
    fmt_state_t        state_next;
    logic [DIM_W-1:0]  m_q;
    logic [DIM_W-1:0]  n_q;
    logic [DIM_W-1:0]  r_q;
    logic [DIM_W-1:0]  c_q;
    logic              lf_phase;

    logic              dims_ok_c;
    logic              last_col_c;
    logic              last_row_c;
    logic              out_free_c;
    logic              load_c;
    logic [BYTE_W-1:0] load_byte_c;
    logic              sub_start_c;
    logic              sub_ready_c;
    logic [BYTE_W-1:0] sub_byte_c;
    logic              sub_valid_c;
    logic              sub_last_c;

    assign dims_ok_c  = (i_m != 3'd0) && (32'(i_m) <= MAX_DIM) &&
                        (i_n != 3'd0) && (32'(i_n) <= MAX_DIM);
    assign last_col_c = (c_q == (n_q - 3'd1));
    assign last_row_c = (r_q == (m_q - 3'd1));
    // Output register may take a new byte when empty or being drained this edge.
    assign out_free_c = !o_tx_valid || i_tx_ready;

    bin2dec_serial u_b2d (
        .clk     (clk),
        .rst     (rst),
        .start   (sub_start_c),
        .value   (i_rd_data),
        .ready   (sub_ready_c),
        .byte_c  (sub_byte_c),
        .valid_c (sub_valid_c),
        .last_c  (sub_last_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and selection of the byte to load into the output register.
    always_comb begin
        state_next  = state;
        load_c      = 1'b0;
        load_byte_c = '0;
        sub_start_c = 1'b0;
        sub_ready_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start && dims_ok_c) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: state_next = ST_WAIT;
            ST_WAIT: begin
                sub_start_c = 1'b1;
                state_next  = ST_CONV;
            end
            ST_CONV: begin
                sub_ready_c = out_free_c;
                if (sub_valid_c && out_free_c) begin
                    load_c      = 1'b1;
                    load_byte_c = sub_byte_c;
                    if (sub_last_c) begin
                        state_next = ST_SEP;
                    end
                end
            end
            ST_SEP: begin
                if (out_free_c) begin
                    load_c = 1'b1;
                    if (!last_col_c) begin
                        load_byte_c = ASC_SPACE;
                        state_next  = ST_READ;
                    end else if (!lf_phase) begin
                        load_byte_c = ASC_CR;
                    end else begin
                        load_byte_c = ASC_LF;
                        state_next  = last_row_c ? ST_FLUSH : ST_READ;
                    end
                end
            end
            // Hold until the final LF leaves the output register.
            ST_FLUSH: begin
                if (out_free_c) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Registered outputs, address pointer and row/column bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rd_addr  <= '0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            m_q        <= '0;
            n_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            lf_phase   <= 1'b0;
        end else begin
            o_busy <= (state_next != ST_IDLE);
            o_done <= (state_next == ST_DONE);
            o_err  <= (state == ST_IDLE) && i_start && !dims_ok_c;

            if (load_c) begin
                o_tx_data  <= load_byte_c;
                o_tx_valid <= 1'b1;
            end else if (i_tx_ready) begin
                o_tx_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (i_start && dims_ok_c) begin
                        o_rd_addr <= i_base_addr;
                        m_q       <= i_m;
                        n_q       <= i_n;
                        r_q       <= '0;
                        c_q       <= '0;
                        lf_phase  <= 1'b0;
                    end
                end
                ST_CONV: begin
                    // Pointer steps once the element's last digit is accepted; wraps modulo 2^ADDR_W.
                    if (load_c && sub_last_c) begin
                        o_rd_addr <= o_rd_addr + ADDR_W'(1);
                    end
                end
                ST_SEP: begin
                    if (out_free_c) begin
                        if (!last_col_c) begin
                            c_q <= c_q + 3'd1;
                        end else if (!lf_phase) begin
                            lf_phase <= 1'b1;
                        end else begin
                            lf_phase <= 1'b0;
                            c_q      <= '0;
                            r_q      <= r_q + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_ascii_formatter.sv
// Self-checking bench for matrix_ascii_formatter: a storage model, a string
// renderer of the expected text, and a per-cycle compare of the byte stream.
module tb_matrix_ascii_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [8:0]  i_base_addr;
    logic [2:0]  i_m;
    logic [2:0]  i_n;
    logic [8:0]  o_rd_addr;
    logic [31:0] i_rd_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    always #5 clk = ~clk;

    matrix_ascii_formatter dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_m         (i_m),
        .i_n         (i_n),
        .o_rd_addr   (o_rd_addr),
        .i_rd_data   (i_rd_data),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    logic [31:0] mem [512];
    int          checks = 0;
    int          errors = 0;
    string       exp_str = "";
    string       act_str = "";
    int          exp_idx = 0;
    int          done_cnt = 0;
    bit          stall_mode = 1'b0;
    bit          hold_prev = 1'b0;
    logic [7:0]  hold_data = 8'h00;

    // Synchronous storage model.
    always @(posedge clk) i_rd_data <= mem[o_rd_addr];

    // Sink readiness: always ready, or randomly stalling.
    always @(posedge clk) begin
        #1;
        i_tx_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    function automatic string esc(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s.getc(i) == 8'h0D) r = {r, "\\r"};
            else if (s.getc(i) == 8'h0A) r = {r, "\\n"};
            else r = {r, $sformatf("%c", s.getc(i))};
        end
        return r;
    endfunction

    // Expected text from the matrix contents, using plain decimal formatting.
    function automatic string render(input int m, input int n, input int base);
        string s = "";
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                s = {s, $sformatf("%0d", $signed(mem[(base + r * n + c) % 512]))};
                s = {s, (c == n - 1) ? "\r\n" : " "};
            end
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, esc(act), esc(exp));
        end
    endtask

    // Per-cycle stream compare and hold-stability check.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checks++;
                if (!o_tx_valid || o_tx_data !== hold_data) begin
                    errors++;
                    $display("FAIL hold: valid=%0b data=%0h expected held %0h", o_tx_valid, o_tx_data, hold_data);
                end
            end
            if (o_tx_valid && i_tx_ready) begin
                act_str = {act_str, $sformatf("%c", o_tx_data)};
                checks++;
                if (exp_idx >= exp_str.len()) begin
                    errors++;
                    $display("FAIL byte: unexpected byte %0h", o_tx_data);
                end else if (o_tx_data !== exp_str.getc(exp_idx)) begin
                    errors++;
                    $display("FAIL byte[%0d]: got %0h expected %0h", exp_idx, o_tx_data, exp_str.getc(exp_idx));
                end
                exp_idx++;
            end
            hold_prev = o_tx_valid && !i_tx_ready;
            hold_data = o_tx_data;
            if (o_done) done_cnt++;
        end
    end

    task automatic pulse_start(input int m, input int n, input int base);
        @(posedge clk);
        #2;
        i_start     = 1'b1;
        i_m         = 3'(m);
        i_n         = 3'(n);
        i_base_addr = 9'(base);
        @(posedge clk);
        #2;
        i_start = 1'b0;
    endtask

    task automatic run_case(input string name, input int m, input int n, input int base,
                            input bit stall, input bit poke, input string lit);
        int cyc = 0;
        stall_mode = stall;
        exp_str    = render(m, n, base);
        exp_idx    = 0;
        act_str    = "";
        done_cnt   = 0;
        pulse_start(m, n, base);
        while (done_cnt == 0 && cyc < 5000) begin
            @(posedge clk);
            #2;
            cyc++;
            if (poke && cyc == 15) begin
                i_start     = 1'b1;
                i_m         = 3'd1;
                i_n         = 3'd1;
                i_base_addr = 9'd0;
            end else begin
                i_start = 1'b0;
            end
        end
        check({name, "_timeout"}, 32'(cyc < 5000), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        check({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({name, "_busy_after"}, 32'(o_busy), 32'd0);
        check_str({name, "_stream"}, act_str, exp_str);
        if (lit != "") check_str({name, "_literal"}, act_str, lit);
        stall_mode = 1'b0;
    endtask

    task automatic err_case(input string name, input int m, input int n);
        exp_str  = "";
        exp_idx  = 0;
        done_cnt = 0;
        pulse_start(m, n, 0);
        check({name, "_err_pulse"}, 32'(o_err), 32'd1);
        check({name, "_err_busy"}, 32'(o_busy), 32'd0);
        @(posedge clk);
        #2;
        check({name, "_err_clear"}, 32'(o_err), 32'd0);
        repeat (6) @(posedge clk);
        #2;
        check({name, "_err_novalid"}, 32'(o_tx_valid), 32'd0);
        check({name, "_err_idle"}, 32'(o_busy), 32'd0);
        check({name, "_err_nodone"}, 32'(done_cnt), 32'd0);
    endtask

    string s35;
    string lit22;

    initial begin
        rst         = 1'b1;
        i_start     = 1'b0;
        i_m         = 3'd0;
        i_n         = 3'd0;
        i_base_addr = 9'd0;
        i_tx_ready  = 1'b1;
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        lit22 = "1 -20\r\n0 2147483647\r\n";

        repeat (3) @(posedge clk);
        #2;
        check("rst_addr", 32'(o_rd_addr), 32'd0);
        check("rst_data", 32'(o_tx_data), 32'd0);
        check("rst_valid", 32'(o_tx_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        rst = 1'b0;

        mem[16] = 32'd1;
        mem[17] = -32'sd20;
        mem[18] = 32'd0;
        mem[19] = 32'h7FFF_FFFF;
        mem[32] = 32'h8000_0000;
        mem[33] = 32'd0;
        check_str("model_2x2", render(2, 2, 16), lit22);
        check_str("model_min", render(1, 1, 32), "-2147483648\r\n");

        run_case("m2x2", 2, 2, 16, 1'b0, 1'b0, lit22);
        run_case("min1x1", 1, 1, 32, 1'b0, 1'b0, "-2147483648\r\n");
        run_case("zero1x1", 1, 1, 33, 1'b0, 1'b0, "0\r\n");

        err_case("m0", 0, 3);
        err_case("n6", 2, 6);
        err_case("m7", 7, 1);

        mem[64] = 32'd7;           mem[65] = -32'sd1;        mem[66] = 32'd100;
        mem[67] = -32'sd999;       mem[68] = 32'd12345;      mem[69] = 32'd0;
        mem[70] = 32'h8000_0000;   mem[71] = 32'h7FFF_FFFF;  mem[72] = 32'd10;
        mem[73] = -32'sd10;        mem[74] = 32'd1000000000; mem[75] = -32'sd1000000000;
        mem[76] = 32'd5;           mem[77] = 32'd42;         mem[78] = -32'sd3;
        run_case("m3x5", 3, 5, 64, 1'b0, 1'b0, "");
        s35 = act_str;
        run_case("m3x5_stall", 3, 5, 64, 1'b1, 1'b0, "");
        check_str("stall_vs_nostall", act_str, s35);

        for (int i = 0; i < 25; i++) mem[100 + i] = 32'(i * 37 - 400);
        run_case("m5x5_stall", 5, 5, 100, 1'b1, 1'b0, "");

        // Reset in the middle of the first element's digit scan.
        exp_str = lit22;
        exp_idx = 0;
        act_str = "";
        pulse_start(2, 2, 16);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("midrst_valid", 32'(o_tx_valid), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_done", 32'(o_done), 32'd0);
        rst = 1'b0;
        run_case("after_rst", 2, 2, 16, 1'b0, 1'b0, lit22);

        run_case("poke_busy", 2, 2, 16, 1'b0, 1'b1, lit22);

        mem[511] = -32'sd7;
        mem[0]   = 32'd123;
        run_case("wrap", 1, 2, 511, 1'b0, 1'b0, "-7 123\r\n");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
